// File: rtl/xgmii_rx_meter.sv
// XGMII receive meter: frame delineation, source IP / timestamp capture,
// per-frame latency and per-window packet/byte rate publication.
module xgmii_rx_meter #(
  parameter int unsigned SEC_CYCLES = 156250000,
  parameter logic [15:0] MAX_LEN    = 16'd1518,
  parameter int unsigned TS_OFFSET  = 42
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic [31:0] global_counter,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput,
  output logic [23:0] rx_latency,
  output logic [31:0] rx_ipv4_ip,
  output logic [31:0] rx_err_count,
  output logic        rx_frame_done
);

  localparam int unsigned WC_W    = 14;
  localparam int unsigned LEN_W   = WC_W + 3;
  localparam int unsigned IP_OFF  = 26;
  localparam int unsigned MIN_LEN = 64;

  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

  state_t            state, state_next;
  logic [WC_W-1:0]   word_cnt;
  logic [31:0]       ip_cap;
  logic [31:0]       ts_cap;
  logic [31:0]       win_cnt;
  logic              latch_q;
  logic [31:0]       pkt_acc;
  logic [31:0]       byte_acc;

  logic              start_c;
  logic              term_hit_c;
  logic [2:0]        term_lane_c;
  logic              ctrl_err_c;
  logic [LEN_W-1:0]  len_c;
  logic [LEN_W-1:0]  run_len_c;
  logic              good_c;
  logic              err_inc_c;
  logic              clr_c;
  logic              adv_c;
  logic [31:0]       lat_diff_c;
  logic [23:0]       lat_c;
  logic [32:0]       byte_sum_c;

  assign start_c = xgmii_rxc[0] && (xgmii_rxd[7:0] == 8'hFB);

  // Lowest terminate lane; any control lane below it (or anywhere, if no
  // terminate) is a framing error. Lanes above the terminate are idle fill.
  always_comb begin
    term_hit_c  = 1'b0;
    term_lane_c = '0;
    ctrl_err_c  = 1'b0;
    for (int l = 7; l >= 0; l--) begin
      if (xgmii_rxc[l] && (xgmii_rxd[8*l +: 8] == 8'hFD)) begin
        term_hit_c  = 1'b1;
        term_lane_c = 3'(l);
      end
    end
    for (int l = 0; l < 8; l++) begin
      if (xgmii_rxc[l] && (!term_hit_c || (3'(l) < term_lane_c))) ctrl_err_c = 1'b1;
    end
  end

  assign len_c     = {word_cnt, 3'b000} + LEN_W'(term_lane_c);
  assign run_len_c = {word_cnt, 3'b000} + LEN_W'(8);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    good_c     = 1'b0;
    err_inc_c  = 1'b0;
    clr_c      = 1'b0;
    adv_c      = 1'b0;
    case (state)
      IDLE: begin
        if (start_c) begin
          state_next = DATA;
          clr_c      = 1'b1;
        end
      end
      DATA: begin
        if (start_c) begin
          err_inc_c = 1'b1;
          clr_c     = 1'b1;
        end else if (term_hit_c && !ctrl_err_c) begin
          state_next = IDLE;
          if ((len_c >= LEN_W'(MIN_LEN)) && (len_c <= LEN_W'(MAX_LEN))) good_c = 1'b1;
          else                                                          err_inc_c = 1'b1;
        end else if (ctrl_err_c || (run_len_c > LEN_W'(MAX_LEN))) begin
          state_next = DROP;
          err_inc_c  = 1'b1;
        end else begin
          adv_c = 1'b1;
        end
      end
      DROP: begin
        if (start_c) begin
          state_next = DATA;
          clr_c      = 1'b1;
        end else if (term_hit_c) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Word counter and header field capture; capture bytes may straddle words.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      word_cnt <= '0;
      ip_cap   <= '0;
      ts_cap   <= '0;
    end else if (clr_c) begin
      word_cnt <= '0;
      ip_cap   <= '0;
      ts_cap   <= '0;
    end else if (adv_c) begin
      word_cnt <= word_cnt + WC_W'(1);
      for (int i = 0; i < 4; i++) begin
        if (word_cnt == WC_W'((IP_OFF + i) / 8))
          ip_cap[8*(3-i) +: 8] <= xgmii_rxd[8*((IP_OFF + i) % 8) +: 8];
        if (word_cnt == WC_W'((TS_OFFSET + i) / 8))
          ts_cap[8*(3-i) +: 8] <= xgmii_rxd[8*((TS_OFFSET + i) % 8) +: 8];
      end
    end
  end

  assign lat_diff_c = global_counter - ts_cap;
  assign lat_c      = (|lat_diff_c[31:24]) ? 24'hFFFFFF : lat_diff_c[23:0];
  assign byte_sum_c = {1'b0, byte_acc} + 33'(len_c);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_frame_done <= 1'b0;
      rx_ipv4_ip    <= '0;
      rx_latency    <= '0;
      rx_err_count  <= '0;
    end else begin
      rx_frame_done <= good_c;
      if (good_c) begin
        rx_ipv4_ip <= ip_cap;
        rx_latency <= lat_c;
      end
      if (err_inc_c && (rx_err_count != 32'hFFFFFFFF)) rx_err_count <= rx_err_count + 32'd1;
    end
  end

  // Window timer: latch_q marks the cycle in which the rates are published.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      win_cnt <= 32'(SEC_CYCLES - 1);
      latch_q <= 1'b0;
    end else begin
      latch_q <= (win_cnt == 32'd0);
      if (win_cnt == 32'd0) win_cnt <= 32'(SEC_CYCLES - 1);
      else                  win_cnt <= win_cnt - 32'd1;
    end
  end

  // A frame finishing in the publish cycle seeds the new window.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pkt_acc       <= '0;
      byte_acc      <= '0;
      rx_pps        <= '0;
      rx_throughput <= '0;
    end else if (latch_q) begin
      rx_pps        <= pkt_acc;
      rx_throughput <= byte_acc;
      pkt_acc       <= good_c ? 32'd1 : 32'd0;
      byte_acc      <= good_c ? 32'(len_c) : 32'd0;
    end else if (good_c) begin
      if (pkt_acc != 32'hFFFFFFFF) pkt_acc <= pkt_acc + 32'd1;
      byte_acc <= byte_sum_c[32] ? 32'hFFFFFFFF : byte_sum_c[31:0];
    end
  end

endmodule

// File: tb/tb_xgmii_rx_meter.sv
// Bench for xgmii_rx_meter: frames built byte-by-byte, expectations from a
// frame-level model (length rules, window arithmetic on clock edge numbers).
module tb_xgmii_rx_meter;

  localparam int unsigned SEC = 1000;
  localparam logic [63:0] IDLE_D = {8{8'h07}};

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [31:0] global_counter;
  logic [31:0] rx_pps;
  logic [31:0] rx_throughput;
  logic [23:0] rx_latency;
  logic [31:0] rx_ipv4_ip;
  logic [31:0] rx_err_count;
  logic        rx_frame_done;

  xgmii_rx_meter #(.SEC_CYCLES(SEC)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .xgmii_rxd      (xgmii_rxd),
    .xgmii_rxc      (xgmii_rxc),
    .global_counter (global_counter),
    .rx_pps         (rx_pps),
    .rx_throughput  (rx_throughput),
    .rx_latency     (rx_latency),
    .rx_ipv4_ip     (rx_ipv4_ip),
    .rx_err_count   (rx_err_count),
    .rx_frame_done  (rx_frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int          checks = 0;
  int          errors = 0;
  int          edge_no = 0;
  int          pkt_win [0:15];
  longint      byte_win [0:15];
  logic [31:0] exp_ip;
  logic [23:0] exp_lat;
  logic [31:0] exp_err;

  // Number of rising edges since reset release; edge k is the k-th sample.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) edge_no <= 0;
    else            edge_no <= edge_no + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      pkt_win[i]  = 0;
      byte_win[i] = 0;
    end
    exp_ip  = '0;
    exp_lat = '0;
    exp_err = '0;
  endtask

  task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
    xgmii_rxd = d;
    xgmii_rxc = c;
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_word(IDLE_D, 8'hFF);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pps"}, rx_pps, 32'd0);
    chk({tag, "_thr"}, rx_throughput, 32'd0);
    chk({tag, "_lat"}, 32'(rx_latency), 32'd0);
    chk({tag, "_ip"},  rx_ipv4_ip, 32'd0);
    chk({tag, "_err"}, rx_err_count, 32'd0);
    chk({tag, "_done"}, 32'(rx_frame_done), 32'd0);
  endtask

  // fe_word >= 0 puts an FE control byte in that data word; trunc >= 0 stops
  // after that many data words with no terminate.
  task automatic send_frame(input int len, input logic [31:0] ip, input logic [31:0] ts,
                            input logic [31:0] gc, input int fe_word, input int trunc);
    logic [7:0]  fb [0:2047];
    logic [63:0] d;
    logic [7:0]  c;
    logic [31:0] diff;
    logic        good;
    int          nfull;
    int          rem;
    int          ev_edge;
    int          w;
    nfull = len / 8;
    rem   = len % 8;
    for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
    fb[26] = ip[31:24]; fb[27] = ip[23:16]; fb[28] = ip[15:8]; fb[29] = ip[7:0];
    fb[42] = ts[31:24]; fb[43] = ts[23:16]; fb[44] = ts[15:8]; fb[45] = ts[7:0];
    drive_word({8'hD5, {6{8'h55}}, 8'hFB}, 8'h01);
    for (int k = 0; k < nfull; k++) begin
      if (k == trunc) return;
      for (int l = 0; l < 8; l++) d[8*l +: 8] = fb[8*k + l];
      c = 8'h00;
      if (k == fe_word) begin
        d[15:8] = 8'hFE;
        c       = 8'h02;
      end
      global_counter = $urandom;
      drive_word(d, c);
    end
    for (int l = 0; l < 8; l++) begin
      if (l < rem)       begin d[8*l +: 8] = fb[8*nfull + l]; c[l] = 1'b0; end
      else if (l == rem) begin d[8*l +: 8] = 8'hFD;           c[l] = 1'b1; end
      else               begin d[8*l +: 8] = 8'h07;           c[l] = 1'b1; end
    end
    global_counter = gc;
    ev_edge = edge_no + 1;
    drive_word(d, c);
    global_counter = $urandom;
    good = (fe_word < 0) && (len >= 64) && (len <= 1518);
    if (good) begin
      w = (ev_edge - 1) / int'(SEC);
      if (w < 16) begin
        pkt_win[w]++;
        byte_win[w] += len;
      end
      diff    = gc - ts;
      exp_lat = (diff > 32'h00FFFFFF) ? 24'hFFFFFF : diff[23:0];
      exp_ip  = ip;
    end else begin
      exp_err++;
    end
    chk($sformatf("done_len%0d", len), 32'(rx_frame_done), 32'(good));
    chk($sformatf("lat_len%0d", len), 32'(rx_latency), 32'(exp_lat));
    chk($sformatf("ip_len%0d", len), rx_ipv4_ip, exp_ip);
    chk($sformatf("err_len%0d", len), rx_err_count, exp_err);
    idle(1);
    chk($sformatf("done_off_len%0d", len), 32'(rx_frame_done), 32'd0);
  endtask

  task automatic chk_window(input int w);
    while (edge_no < (w + 1) * int'(SEC) + 1) idle(1);
    chk($sformatf("pps_w%0d", w), rx_pps, 32'(pkt_win[w]));
    chk($sformatf("thr_w%0d", w), rx_throughput, 32'(byte_win[w]));
  endtask

  initial begin
    logic [31:0] ts;
    logic [31:0] ip;
    int          mode;
    int          len;
    sys_rst_n      = 1'b0;
    xgmii_rxd      = IDLE_D;
    xgmii_rxc      = 8'hFF;
    global_counter = '0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    chk_all_zero("reset");
    sys_rst_n = 1'b1;

    // Window 0: five good minimum-size frames.
    send_frame(64, 32'h0A001569, 32'h00001000, 32'h00001234, -1, -1);
    chk("lat_directed", 32'(rx_latency), 32'h00000234);
    for (int n = 0; n < 4; n++) begin
      ts = $urandom;
      send_frame(64, $urandom, ts, ts + 32'($urandom_range(0, 32'h00FFFFFF)), -1, -1);
      idle(2);
    end
    chk_window(0);

    // Window 1: a 67-byte frame, then a frame terminating on the publish cycle.
    send_frame(67, $urandom, 32'h100, 32'h200, -1, -1);
    while (edge_no < 2 * int'(SEC) - 9) idle(1);
    send_frame(64, $urandom, 32'h500, 32'h600, -1, -1);
    chk_window(1);

    // Error cases and boundaries.
    send_frame(100, $urandom, 32'h10, 32'h20, 4, -1);
    send_frame(96, 32'hC0A80101, 32'h1000, 32'h1800, -1, -1);
    send_frame(80, $urandom, 32'h0, 32'h0, -1, 3);
    exp_err++;
    send_frame(72, 32'h01020304, 32'h0, 32'h42, -1, -1);
    send_frame(40, $urandom, 32'h0, 32'h0, -1, -1);
    send_frame(64, $urandom, 32'h0, 32'h02000000, -1, -1);
    chk("lat_sat", 32'(rx_latency), 32'h00FFFFFF);
    send_frame(63, $urandom, 32'h0, 32'h0, -1, -1);
    send_frame(1518, $urandom, 32'hFFFFFFF0, 32'h00000010, -1, -1);
    send_frame(1519, $urandom, 32'h0, 32'h0, -1, -1);
    send_frame(1600, $urandom, 32'h0, 32'h0, -1, -1);
    chk_window(edge_no / int'(SEC));

    // Randomized mix of good, FE-corrupted and runt frames.
    for (int n = 0; n < 12; n++) begin
      mode = int'($urandom_range(0, 3));
      len  = int'($urandom_range(64, 256));
      ts   = $urandom;
      ip   = $urandom;
      case (mode)
        2:       send_frame(len, ip, ts, ts + 32'($urandom_range(0, 32'h03FFFFFF)),
                            int'($urandom_range(0, len / 8 - 1)), -1);
        3:       send_frame(int'($urandom_range(20, 63)), ip, ts, ts + 32'd5, -1, -1);
        default: send_frame(len, ip, ts, ts + 32'($urandom_range(0, 32'h03FFFFFF)), -1, -1);
      endcase
      idle(int'($urandom_range(0, 3)));
    end
    chk_window(edge_no / int'(SEC));

    // Reset in mid-frame; the trailing words and terminate must be ignored.
    send_frame(128, $urandom, 32'h0, 32'h0, -1, 5);
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 3; n++) drive_word({$urandom, $urandom}, 8'h00);
    drive_word({{7{8'h07}}, 8'hFD}, 8'hFF);
    chk("trail_done", 32'(rx_frame_done), 32'd0);
    chk("trail_err", rx_err_count, 32'd0);
    idle(2);
    send_frame(64, 32'h0A0A0A0A, 32'h7, 32'h9, -1, -1);
    chk_window(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
